wired_cdb_arbiter: RTL and testbench

Shares the two common-data-bus (CDB) write ports among the ALU, LSU and MDU result producers. It sits between the per-unit commit FIFOs and the ROB/wakeup network. It resolves ROB bank conflicts by steering each result to the port that owns its ROB bank. Within each bank it applies fixed priority ALU0 > ALU1 > LSU > MDU, with an anti-starvation override for LSU and MDU. Granted results are registered onto `cdb_o`.

---
 rtl/wired_cdb_arbiter_pkg.sv | 33 +++
 rtl/wired_cdb_port_sel.sv | 39 +++
 rtl/wired_cdb_arbiter.sv | 119 +++++++++++
 tb/tb_wired_cdb_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wired_cdb_arbiter_pkg.sv
// Shared CDB types and the compile-time default for the LSU/MDU starvation limit.

`ifndef _WIRED_PARAM_CDB_STARVE_LIMIT
`define _WIRED_PARAM_CDB_STARVE_LIMIT 8
`endif

package wired_cdb_arbiter_pkg;

    localparam int ROB_ID_W   = 6;
    localparam int CDB_DATA_W = 32;
    localparam int NUM_SRC    = 4;
    localparam int NUM_PORTS  = 2;
    // ROB bank select bit inside a ROB id; port k serves bank k.
    localparam int BANK_BIT   = 0;

    typedef logic [ROB_ID_W-1:0] rob_rid_t;

    typedef struct packed {
        logic                  valid;
        rob_rid_t              wid;
        logic [CDB_DATA_W-1:0] data;
        logic                  exc;
    } pipeline_cdb_t;

    // Source index doubles as the fixed priority order (lower value wins).
    typedef enum logic [1:0] {
        SRC_ALU0 = 2'd0,
        SRC_ALU1 = 2'd1,
        SRC_LSU  = 2'd2,
        SRC_MDU  = 2'd3
    } cdb_src_e;

endpackage

// File: rtl/wired_cdb_port_sel.sv
// Per-bank 4-way priority selector: ALU0 > ALU1 > LSU > MDU, with a starved
// LSU (then a starved MDU) promoted above everything else.

module wired_cdb_port_sel
    import wired_cdb_arbiter_pkg::*;
(
    input  logic [NUM_SRC-1:0] req_i,
    input  logic               lsu_ovr_i,
    input  logic               mdu_ovr_i,
    output logic [NUM_SRC-1:0] gnt_o,
    output logic               gnt_vld_o,
    output cdb_src_e           gnt_src_o
);

    // Pick the winning source; at most one grant bit is set.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_o     = '0;
        gnt_src_o = SRC_ALU0;
        gnt_vld_o = |req_i;

        if (lsu_ovr_i && req_i[SRC_LSU]) begin
            gnt_src_o = SRC_LSU;
        end else if (mdu_ovr_i && req_i[SRC_MDU]) begin
            gnt_src_o = SRC_MDU;
        end else if (req_i[SRC_ALU0]) begin
            gnt_src_o = SRC_ALU0;
        end else if (req_i[SRC_ALU1]) begin
            gnt_src_o = SRC_ALU1;
        end else if (req_i[SRC_LSU]) begin
            gnt_src_o = SRC_LSU;
        end else if (req_i[SRC_MDU]) begin
            gnt_src_o = SRC_MDU;
        end

        gnt_o[gnt_src_o] = gnt_vld_o;
    end

endmodule

// File: rtl/wired_cdb_arbiter.sv
// Shares the two CDB write ports among ALU0/ALU1/LSU/MDU. Each result is
// steered to the port owning its ROB bank, arbitrated there, and registered
// onto cdb_o one cycle later. LSU/MDU carry saturating starvation counters.

module wired_cdb_arbiter
    import wired_cdb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = `_WIRED_PARAM_CDB_STARVE_LIMIT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  pipeline_cdb_t [1:0]           alu_cdb_i,
    output logic [1:0]                    alu_ready_o,
    input  pipeline_cdb_t                 lsu_cdb_i,
    output logic                          lsu_ready_o,
    input  pipeline_cdb_t                 mdu_cdb_i,
    output logic                          mdu_ready_o,
    output pipeline_cdb_t [NUM_PORTS-1:0] cdb_o
);

    localparam int                WAIT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    pipeline_cdb_t                 src_cdb   [NUM_SRC];
    logic [NUM_SRC-1:0]            port_req  [NUM_PORTS];
    logic [NUM_SRC-1:0]            port_gnt  [NUM_PORTS];
    logic                          port_vld  [NUM_PORTS];
    cdb_src_e                      port_src  [NUM_PORTS];
    logic [NUM_SRC-1:0]            src_gnt;
    logic                          accept_en;
    logic                          lsu_starved;
    logic                          mdu_starved;

    logic [WAIT_W-1:0]             lsu_wait_q, lsu_wait_d;
    logic [WAIT_W-1:0]             mdu_wait_q, mdu_wait_d;
    pipeline_cdb_t [NUM_PORTS-1:0] cdb_q, cdb_d;

    // Nothing is accepted while in reset or during a flush.
    assign accept_en   = rst_n && !flush_i;
    assign lsu_starved = (lsu_wait_q == WAIT_MAX);
    assign mdu_starved = (mdu_wait_q == WAIT_MAX);

    // Gather sources in priority order and split requests by ROB bank.
    always_comb begin
        src_cdb[SRC_ALU0] = alu_cdb_i[0];
        src_cdb[SRC_ALU1] = alu_cdb_i[1];
        src_cdb[SRC_LSU]  = lsu_cdb_i;
        src_cdb[SRC_MDU]  = mdu_cdb_i;
        for (int k = 0; k < NUM_PORTS; k++) begin
            port_req[k] = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                port_req[k][s] = src_cdb[s].valid && (src_cdb[s].wid[BANK_BIT] == 1'(k));
            end
        end
    end

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        wired_cdb_port_sel u_sel (
            .req_i     (port_req[k]),
            .lsu_ovr_i (lsu_starved),
            .mdu_ovr_i (mdu_starved),
            .gnt_o     (port_gnt[k]),
            .gnt_vld_o (port_vld[k]),
            .gnt_src_o (port_src[k])
        );
    end

    // A source lives in exactly one bank, so OR-ing the port grants is safe.
    assign src_gnt     = port_gnt[0] | port_gnt[1];
    assign alu_ready_o = {src_gnt[SRC_ALU1], src_gnt[SRC_ALU0]} & {2{accept_en}};
    assign lsu_ready_o = src_gnt[SRC_LSU] && accept_en;
    assign mdu_ready_o = src_gnt[SRC_MDU] && accept_en;

    // Copy each port's winning payload onto the next CDB value.
    always_comb begin
        cdb_d = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (port_vld[k] && accept_en) begin
                cdb_d[k]       = src_cdb[port_src[k]];
                cdb_d[k].valid = 1'b1;
            end
        end
    end

    // Starvation counters: clear on grant, idle or flush; otherwise count up to the limit.
    always_comb begin
        lsu_wait_d = lsu_wait_q;
        if (flush_i || !lsu_cdb_i.valid || src_gnt[SRC_LSU]) begin
            lsu_wait_d = '0;
        end else if (lsu_wait_q != WAIT_MAX) begin
            lsu_wait_d = lsu_wait_q + WAIT_W'(1);
        end

        mdu_wait_d = mdu_wait_q;
        if (flush_i || !mdu_cdb_i.valid || src_gnt[SRC_MDU]) begin
            mdu_wait_d = '0;
        end else if (mdu_wait_q != WAIT_MAX) begin
            mdu_wait_d = mdu_wait_q + WAIT_W'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            cdb_q      <= '0;
            lsu_wait_q <= '0;
            mdu_wait_q <= '0;
        end else begin
            cdb_q      <= cdb_d;
            lsu_wait_q <= lsu_wait_d;
            mdu_wait_q <= mdu_wait_d;
        end
    end

    assign cdb_o = cdb_q;

endmodule

// File: tb/tb_wired_cdb_arbiter.sv
// Directed bench for wired_cdb_arbiter with STARVE_LIMIT=3.

module tb_wired_cdb_arbiter;
    import wired_cdb_arbiter_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                flush;
    pipeline_cdb_t [1:0] alu_cdb;
    pipeline_cdb_t       lsu_cdb;
    pipeline_cdb_t       mdu_cdb;
    logic [1:0]          alu_ready;
    logic                lsu_ready;
    logic                mdu_ready;
    pipeline_cdb_t [1:0] cdb;

    int checks   = 0;
    int failures = 0;

    wired_cdb_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .alu_cdb_i   (alu_cdb),
        .alu_ready_o (alu_ready),
        .lsu_cdb_i   (lsu_cdb),
        .lsu_ready_o (lsu_ready),
        .mdu_cdb_i   (mdu_cdb),
        .mdu_ready_o (mdu_ready),
        .cdb_o       (cdb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic pipeline_cdb_t mk(input int wid, input logic [31:0] data);
        pipeline_cdb_t c;
        c.valid = 1'b1;
        c.wid   = rob_rid_t'(wid);
        c.data  = data;
        c.exc   = 1'b0;
        return c;
    endfunction

    task automatic clear_inputs();
        alu_cdb = '0;
        lsu_cdb = '0;
        mdu_cdb = '0;
        flush   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        alu_cdb[0] = mk(4, 32'h1111_0000);
        lsu_cdb    = mk(2, 32'h1111_0002);
        #1;
        checks++;
        if ({alu_ready, lsu_ready, mdu_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready: got %b want 0000", {alu_ready, lsu_ready, mdu_ready});
        end
        tick();
        tick();
        checks++;
        if (cdb !== '0) begin
            failures++;
            $display("FAIL reset_cdb: got %h want 0", cdb);
        end
        checks++;
        if (dut.lsu_wait_q !== 2'd0 || dut.mdu_wait_q !== 2'd0) begin
            failures++;
            $display("FAIL reset_wait: got lsu=%0d mdu=%0d want 0/0", dut.lsu_wait_q, dut.mdu_wait_q);
        end
        clear_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bank_split();
        alu_cdb[0] = mk(4, 32'hA000_0004);
        alu_cdb[1] = mk(5, 32'hA000_0005);
        lsu_cdb    = mk(6, 32'hC000_0006);
        #1;
        checks++;
        if (alu_ready !== 2'b11 || lsu_ready !== 1'b0 || mdu_ready !== 1'b0) begin
            failures++;
            $display("FAIL split_c0_ready: got alu=%b lsu=%b mdu=%b want 11/0/0", alu_ready, lsu_ready, mdu_ready);
        end
        tick();
        checks++;
        if (cdb[0] !== mk(4, 32'hA000_0004) || cdb[1] !== mk(5, 32'hA000_0005)) begin
            failures++;
            $display("FAIL split_c1_cdb: got %h / %h want wid 4 / wid 5", cdb[0], cdb[1]);
        end
        alu_cdb = '0;
        #1;
        checks++;
        if (lsu_ready !== 1'b1 || alu_ready !== 2'b00) begin
            failures++;
            $display("FAIL split_c1_ready: got alu=%b lsu=%b want 00/1", alu_ready, lsu_ready);
        end
        tick();
        checks++;
        if (cdb[0] !== mk(6, 32'hC000_0006) || cdb[1] !== '0) begin
            failures++;
            $display("FAIL split_c2_cdb: got %h / %h want wid 6 / 0", cdb[0], cdb[1]);
        end
        clear_inputs();
        tick();
        checks++;
        if (cdb !== '0) begin
            failures++;
            $display("FAIL split_drain: got %h want 0", cdb);
        end
    endtask

    task automatic test_bank_conflict();
        alu_cdb[0] = mk(2, 32'hB000_0002);
        alu_cdb[1] = mk(6, 32'hB000_0006);
        #1;
        checks++;
        if (alu_ready !== 2'b01) begin
            failures++;
            $display("FAIL conflict_c0_ready: got %b want 01", alu_ready);
        end
        tick();
        checks++;
        if (cdb[0] !== mk(2, 32'hB000_0002) || cdb[1] !== '0) begin
            failures++;
            $display("FAIL conflict_c1_cdb: got %h / %h want wid 2 / 0", cdb[0], cdb[1]);
        end
        alu_cdb[0] = '0;
        #1;
        checks++;
        if (alu_ready !== 2'b10) begin
            failures++;
            $display("FAIL conflict_c1_ready: got %b want 10", alu_ready);
        end
        tick();
        checks++;
        if (cdb[0] !== mk(6, 32'hB000_0006) || cdb[1] !== '0) begin
            failures++;
            $display("FAIL conflict_c2_cdb: got %h / %h want wid 6 / 0", cdb[0], cdb[1]);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_starvation();
        alu_cdb[0] = mk(1, 32'hA100_0001);
        mdu_cdb    = mk(3, 32'hD000_0003);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mdu_ready !== 1'b0 || alu_ready !== 2'b01 || dut.mdu_wait_q !== 2'(i)) begin
                failures++;
                $display("FAIL starve_deny_c%0d: got mdu=%b alu=%b wait=%0d want 0/01/%0d",
                         i, mdu_ready, alu_ready, dut.mdu_wait_q, i);
            end
            tick();
            checks++;
            if (cdb[1] !== mk(1, 32'hA100_0001)) begin
                failures++;
                $display("FAIL starve_alu_cdb_c%0d: got %h want wid 1", i + 1, cdb[1]);
            end
        end
        #1;
        checks++;
        if (mdu_ready !== 1'b1 || alu_ready !== 2'b00 || dut.mdu_wait_q !== 2'd3) begin
            failures++;
            $display("FAIL starve_c3_grant: got mdu=%b alu=%b wait=%0d want 1/00/3", mdu_ready, alu_ready, dut.mdu_wait_q);
        end
        tick();
        mdu_cdb = '0;
        #1;
        checks++;
        if (cdb[1] !== mk(3, 32'hD000_0003) || dut.mdu_wait_q !== 2'd0) begin
            failures++;
            $display("FAIL starve_c4: got cdb1=%h wait=%0d want wid 3 / 0", cdb[1], dut.mdu_wait_q);
        end
        checks++;
        if (alu_ready !== 2'b01) begin
            failures++;
            $display("FAIL starve_c4_alu: got %b want 01", alu_ready);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_both_starved();
        alu_cdb[0] = mk(2, 32'hA200_0002);
        lsu_cdb    = mk(4, 32'hC000_0004);
        mdu_cdb    = mk(6, 32'hD000_0006);
        tick();
        tick();
        tick();
        #1;
        checks++;
        if (lsu_ready !== 1'b1 || mdu_ready !== 1'b0 || alu_ready !== 2'b00) begin
            failures++;
            $display("FAIL both_c3_ready: got lsu=%b mdu=%b alu=%b want 1/0/00", lsu_ready, mdu_ready, alu_ready);
        end
        checks++;
        if (dut.lsu_wait_q !== 2'd3 || dut.mdu_wait_q !== 2'd3) begin
            failures++;
            $display("FAIL both_c3_wait: got lsu=%0d mdu=%0d want 3/3", dut.lsu_wait_q, dut.mdu_wait_q);
        end
        tick();
        lsu_cdb = '0;
        #1;
        checks++;
        if (cdb[0] !== mk(4, 32'hC000_0004) || dut.mdu_wait_q !== 2'd3) begin
            failures++;
            $display("FAIL both_c4_cdb: got cdb0=%h mdu_wait=%0d want wid 4 / 3", cdb[0], dut.mdu_wait_q);
        end
        checks++;
        if (mdu_ready !== 1'b1 || alu_ready !== 2'b00) begin
            failures++;
            $display("FAIL both_c4_ready: got mdu=%b alu=%b want 1/00", mdu_ready, alu_ready);
        end
        tick();
        mdu_cdb = '0;
        #1;
        checks++;
        if (cdb[0] !== mk(6, 32'hD000_0006) || dut.mdu_wait_q !== 2'd0) begin
            failures++;
            $display("FAIL both_c5_cdb: got cdb0=%h mdu_wait=%0d want wid 6 / 0", cdb[0], dut.mdu_wait_q);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_parallel_low();
        lsu_cdb = mk(2, 32'hC000_0002);
        mdu_cdb = mk(3, 32'hD000_0003);
        #1;
        checks++;
        if (lsu_ready !== 1'b1 || mdu_ready !== 1'b1 || alu_ready !== 2'b00) begin
            failures++;
            $display("FAIL parallel_ready: got lsu=%b mdu=%b alu=%b want 1/1/00", lsu_ready, mdu_ready, alu_ready);
        end
        tick();
        checks++;
        if (cdb[0] !== mk(2, 32'hC000_0002) || cdb[1] !== mk(3, 32'hD000_0003)) begin
            failures++;
            $display("FAIL parallel_cdb: got %h / %h want wid 2 / wid 3", cdb[0], cdb[1]);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_flush();
        alu_cdb[0] = mk(0, 32'hA300_0000);
        lsu_cdb    = mk(2, 32'hC300_0002);
        tick();
        tick();
        checks++;
        if (dut.lsu_wait_q !== 2'd2 || cdb[0] !== mk(0, 32'hA300_0000)) begin
            failures++;
            $display("FAIL flush_pre: got wait=%0d cdb0=%h want 2 / wid 0", dut.lsu_wait_q, cdb[0]);
        end
        flush = 1'b1;
        #1;
        checks++;
        if ({alu_ready, lsu_ready, mdu_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL flush_ready: got %b want 0000", {alu_ready, lsu_ready, mdu_ready});
        end
        tick();
        checks++;
        if (cdb !== '0 || dut.lsu_wait_q !== 2'd0) begin
            failures++;
            $display("FAIL flush_post: got cdb=%h wait=%0d want 0 / 0", cdb, dut.lsu_wait_q);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        alu_cdb[0] = mk(4, 32'hA400_0004);
        alu_cdb[1] = mk(5, 32'hA400_0005);
        lsu_cdb    = mk(6, 32'hC400_0006);
        tick();
        checks++;
        if (cdb[0] !== mk(4, 32'hA400_0004) || dut.lsu_wait_q !== 2'd1) begin
            failures++;
            $display("FAIL rstmid_pre: got cdb0=%h wait=%0d want wid 4 / 1", cdb[0], dut.lsu_wait_q);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({alu_ready, lsu_ready, mdu_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_ready: got %b want 0000", {alu_ready, lsu_ready, mdu_ready});
        end
        tick();
        checks++;
        if (cdb !== '0 || dut.lsu_wait_q !== 2'd0) begin
            failures++;
            $display("FAIL rstmid_post: got cdb=%h wait=%0d want 0 / 0", cdb, dut.lsu_wait_q);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (alu_ready !== 2'b11 || lsu_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_resume_ready: got alu=%b lsu=%b want 11/0", alu_ready, lsu_ready);
        end
        tick();
        checks++;
        if (cdb[0] !== mk(4, 32'hA400_0004) || cdb[1] !== mk(5, 32'hA400_0005)) begin
            failures++;
            $display("FAIL rstmid_resume_cdb: got %h / %h want wid 4 / wid 5", cdb[0], cdb[1]);
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_bank_split();
        test_bank_conflict();
        test_starvation();
        test_both_starved();
        test_parallel_low();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
